// File: rtl/ex_dispatch.sv
// Single-outstanding dispatcher for long-latency ops: accepts one decoded op,
// issues it to the execute unit, waits for completion (with timeout) and writes back.
module ex_dispatch #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_sig,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [4:0]  req_rd,
    output logic [19:0] ex_sig,
    output logic [31:0] ex_src1,
    output logic [31:0] ex_src2,
    output logic        ex_out_valid,
    input  logic [31:0] ex_result,
    input  logic [2:0]  ex_exception,
    input  logic        ex_in_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_exc,
    output logic        busy,
    output logic        stray_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [6:0] cnt;
    logic       legal;
    logic       accept;
    logic       timeout;

    // Legal op: exactly one defined op bit, reserved bits clear.
    assign legal   = $onehot(req_sig[16:0]) && (req_sig[19:17] == 3'b000);
    assign accept  = (state == IDLE) && req_valid;
    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = legal ? ISSUE : WB;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (ex_in_valid || timeout) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            ex_sig    <= '0;
            ex_src1   <= '0;
            ex_src2   <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_exc    <= '0;
            stray_err <= 1'b0;
        end else begin
            if (accept) begin
                ex_sig  <= req_sig;
                ex_src1 <= req_src1;
                ex_src2 <= req_src2;
                wb_rd   <= req_rd;
                if (!legal) begin
                    wb_data <= '0;
                    wb_exc  <= 3'b010;
                end
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 7'd1;
            // A completion in the timeout cycle wins over the timeout.
            if (state == WAIT) begin
                if (ex_in_valid) begin
                    wb_data <= ex_result;
                    wb_exc  <= ex_exception;
                end else if (timeout) begin
                    wb_data <= '0;
                    wb_exc  <= 3'b111;
                end
            end
            if (ex_in_valid && (state != WAIT)) stray_err <= 1'b1;
        end
    end

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign ex_out_valid = (state == ISSUE);
    assign wb_valid     = (state == WB);

endmodule

// File: tb/tb_ex_dispatch.sv
// Randomized self-checking bench for ex_dispatch; expected timing and writeback
// values come from a cycle-count model of accept/issue/wait/writeback.
module tb_ex_dispatch;

    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_sig;
    logic [31:0] req_src1, req_src2;
    logic [4:0]  req_rd;
    logic [19:0] ex_sig;
    logic [31:0] ex_src1, ex_src2;
    logic        ex_out_valid;
    logic [31:0] ex_result;
    logic [2:0]  ex_exception;
    logic        ex_in_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  wb_exc;
    logic        busy;
    logic        stray_err;

    int errors = 0;
    int checks = 0;
    bit stray_exp = 1'b0;

    ex_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_sig(req_sig),
        .req_src1(req_src1), .req_src2(req_src2), .req_rd(req_rd),
        .ex_sig(ex_sig), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_out_valid(ex_out_valid),
        .ex_result(ex_result), .ex_exception(ex_exception), .ex_in_valid(ex_in_valid),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
        .busy(busy), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Legality from the op definition: one op bit among 17, reserved bits zero.
    function automatic bit is_legal(input logic [19:0] s);
        int n = 0;
        for (int i = 0; i < 17; i++) n += int'(s[i]);
        return (n == 1) && (s[19:17] == 3'b000);
    endfunction

    task automatic do_reset();
        req_valid = 0; ex_in_valid = 0;
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        stray_exp = 0;
        step();
    endtask

    // One transaction. resp_k: WAIT-cycle index where the exu answers (-1 = never).
    task automatic run_op(input logic [19:0] sig, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] rd, input int resp_k, input logic [31:0] res,
                          input logic [2:0] exc, input bit hold_req, input string name);
        bit legal;
        int wb_c;
        logic [31:0] exp_d;
        logic [2:0]  exp_e;
        legal = is_legal(sig);
        if (!legal) begin
            wb_c = 1; exp_d = 32'h0; exp_e = 3'b010;
        end else if (resp_k >= 0 && resp_k < TIMEOUT) begin
            wb_c = 3 + resp_k; exp_d = res; exp_e = exc;
        end else begin
            wb_c = 2 + TIMEOUT; exp_d = 32'h0; exp_e = 3'b111;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
        end
        req_valid = 1; req_sig = sig; req_src1 = s1; req_src2 = s2; req_rd = rd;
        step();
        for (int c = 1; c <= wb_c; c++) begin
            if (hold_req && c < wb_c) begin
                req_valid = 1; req_sig = 20'($urandom); req_src1 = $urandom;
                req_src2 = $urandom; req_rd = 5'($urandom);
            end else begin
                req_valid = 0;
            end
            checks++;
            if (ex_out_valid !== (legal && c == 1)) begin
                errors++; $display("FAIL %s ex_out_valid c=%0d: got %b want %b", name, c, ex_out_valid, legal && c == 1);
            end
            checks++;
            if (wb_valid !== (c == wb_c)) begin
                errors++; $display("FAIL %s wb_valid c=%0d: got %b want %b", name, c, wb_valid, c == wb_c);
            end
            checks++;
            if (ex_sig !== sig || ex_src1 !== s1 || ex_src2 !== s2) begin
                errors++; $display("FAIL %s ex_ops c=%0d: got %h/%h/%h want %h/%h/%h", name, c, ex_sig, ex_src1, ex_src2, sig, s1, s2);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy c=%0d: got %b want 1", name, c, busy);
            end
            if (c == wb_c) begin
                checks++;
                if (wb_rd !== rd || wb_data !== exp_d || wb_exc !== exp_e) begin
                    errors++; $display("FAIL %s wb_fields: got rd=%0d data=%h exc=%b want rd=%0d data=%h exc=%b", name, wb_rd, wb_data, wb_exc, rd, exp_d, exp_e);
                end
            end
            ex_result = res; ex_exception = exc;
            ex_in_valid = legal && resp_k >= 0 && c == 2 + resp_k;
            step();
            ex_in_valid = 0;
        end
        req_valid = 0;
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s after_wb: got wb_valid=%b ready=%b busy=%b want 0/1/0", name, wb_valid, req_ready, busy);
        end
        checks++;
        if (stray_err !== stray_exp) begin
            errors++; $display("FAIL %s stray_err: got %b want %b", name, stray_err, stray_exp);
        end
    endtask

    task automatic test_reset();
        rstn = 0; req_valid = 0; req_sig = 0; req_src1 = 0; req_src2 = 0; req_rd = 0;
        ex_in_valid = 0; ex_result = 0; ex_exception = 0;
        #12;
        checks++;
        if (ex_out_valid !== 0 || wb_valid !== 0 || stray_err !== 0 || busy !== 0 ||
            ex_sig !== 0 || ex_src1 !== 0 || ex_src2 !== 0 || wb_rd !== 0 || wb_data !== 0 || wb_exc !== 0) begin
            errors++; $display("FAIL reset_values: got eov=%b wbv=%b se=%b busy=%b sig=%h wbd=%h exc=%b want all 0",
                               ex_out_valid, wb_valid, stray_err, busy, ex_sig, wb_data, wb_exc);
        end
        @(negedge clk);
        rstn = 1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_mul();
        run_op(20'h00001, 32'd6, 32'd7, 5'd5, 1, 32'd42, 3'b000, 0, "mul");
    endtask

    task automatic test_illegal();
        run_op(20'h00003, 32'd1, 32'd2, 5'd9, 0, 32'd55, 3'b000, 0, "two_bits");
        run_op(20'h20000, 32'd3, 32'd4, 5'd10, 0, 32'd55, 3'b000, 0, "reserved_bit");
        run_op(20'h00000, 32'd3, 32'd4, 5'd11, 0, 32'd55, 3'b000, 0, "no_bits");
    endtask

    task automatic test_timeout();
        run_op(20'h00004, 32'hAAAA, 32'h5555, 5'd17, -1, 32'h0, 3'b000, 0, "timeout");
        run_op(20'h10000, 32'h1111, 32'h2222, 5'd3, TIMEOUT - 1, 32'hDEADBEEF, 3'b011, 0, "timeout_race");
        run_op(20'h00100, 32'h1, 32'h2, 5'd4, TIMEOUT - 2, 32'hCAFEF00D, 3'b001, 0, "late_resp");
    endtask

    task automatic test_hold_req();
        run_op(20'h00002, 32'd100, 32'd200, 5'd21, 6, 32'h12345678, 3'b100, 1, "hold_req");
    endtask

    task automatic test_stray();
        ex_in_valid = 1; ex_result = 32'hFFFF; ex_exception = 3'b101;
        step();
        ex_in_valid = 0;
        stray_exp = 1;
        checks++;
        if (stray_err !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL stray_idle: got se=%b wbv=%b want 1/0", stray_err, wb_valid);
        end
        repeat (4) step();
        run_op(20'h00008, 32'd9, 32'd8, 5'd7, 2, 32'd77, 3'b000, 0, "after_stray");
        do_reset();
        checks++;
        if (stray_err !== 1'b0) begin
            errors++; $display("FAIL stray_cleared: got %b want 0", stray_err);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_sig = 20'h00010; req_src1 = 32'h77; req_src2 = 32'h88; req_rd = 5'd12;
        step();
        req_valid = 0;
        repeat (3) step();
        #3 rstn = 0;
        #1;
        checks++;
        if (req_ready !== 1 || busy !== 0 || ex_out_valid !== 0 || wb_valid !== 0 || ex_sig !== 0 ||
            ex_src1 !== 0 || ex_src2 !== 0 || wb_rd !== 0 || wb_data !== 0 || wb_exc !== 0 || stray_err !== 0) begin
            errors++; $display("FAIL reset_mid_values: got rdy=%b busy=%b eov=%b wbv=%b sig=%h src1=%h want idle/zeros",
                               req_ready, busy, ex_out_valid, wb_valid, ex_sig, ex_src1);
        end
        @(negedge clk);
        rstn = 1;
        stray_exp = 0;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wb_valid !== 1'b0 || ex_out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_mid_quiet: got wbv=%b eov=%b want 0/0", wb_valid, ex_out_valid);
            end
            step();
        end
        ex_in_valid = 1;
        step();
        ex_in_valid = 0;
        stray_exp = 1;
        checks++;
        if (stray_err !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL late_resp_stray: got se=%b wbv=%b want 1/0", stray_err, wb_valid);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [19:0] sig;
        int k;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) != 0) sig = 20'(1) << $urandom_range(0, 16);
            else                           sig = 20'($urandom);
            case ($urandom_range(0, 9))
                0:       k = -1;
                1:       k = TIMEOUT - 1;
                default: k = int'($urandom_range(0, 10));
            endcase
            run_op(sig, $urandom, $urandom, 5'($urandom), k, $urandom, 3'($urandom),
                   bit'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_illegal();
        test_timeout();
        test_hold_req();
        test_stray();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_dispatch.md
EX_DISPATCH -- requirements
Module: ex_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100, meaning max cycles waited in WAIT for ex_in_valid (1..127).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core offers a decoded long-latency op.
REQ-005 SHALL have port req_ready  output  1  dispatcher can accept an op this cycle.
REQ-006 SHALL have port req_sig  input  20  one-hot op select (bit0 mul ... bit16 fsgnjn; bits 19:17 reserved).
REQ-007 SHALL have port req_src1 / req_src2  input  32 each  operand values.
REQ-008 SHALL have port req_rd  input  5  destination register tag.
REQ-009 SHALL have port ex_sig  output  20, ex_src1 / ex_src2  output  32 each  registered op and operands to execute unit.
REQ-010 SHALL have port ex_out_valid  output  1  single-cycle issue strobe to execute unit.
REQ-011 SHALL have port ex_result  input  32, ex_exception  input  3, ex_in_valid  input  1  single-cycle completion strobe from execute unit.
REQ-012 SHALL have port wb_valid  output  1, wb_rd  output  5, wb_data  output  32, wb_exc  output  3  single-cycle writeback.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port stray_err  output  1  sticky flag, ex_in_valid seen while not waiting.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, WB; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when IDLE and req_valid=1, latching sig, src1, src2, rd on that edge.
REQ-017 SHALL, for a legal op (exactly one of req_sig[16:0] set, req_sig[19:17]=0), go IDLE->ISSUE, else IDLE->WB with wb_exc=3'b010, wb_data=0, no issue.
REQ-018 SHALL in ISSUE drive ex_out_valid=1 for exactly one cycle with latched ex_sig/ex_src1/ex_src2, then go to WAIT; ex_sig/src held stable until next accept.
REQ-019 SHALL drive ex_out_valid=0 in all states except ISSUE.
REQ-020 SHALL in WAIT increment a 7-bit wait counter from 0 each cycle; counter cleared on entry to WAIT.
REQ-021 SHALL on ex_in_valid=1 in WAIT capture ex_result, ex_exception into wb_data, wb_exc and go to WB.
REQ-022 SHALL on counter reaching TIMEOUT-1 with ex_in_valid=0 go to WB with wb_data=0, wb_exc=3'b111; ex_in_valid in that same cycle takes priority over timeout.
REQ-023 SHALL in WB assert wb_valid=1 for exactly one cycle with wb_rd=latched rd, then return to IDLE.
REQ-024 SHALL set stray_err on ex_in_valid=1 in IDLE, ISSUE or WB; that strobe is otherwise ignored; cleared only by reset.
REQ-025 SHALL give minimum accept-to-wb_valid latency of 3 cycles for legal ops (accept T, issue T+1, ex_in_valid at T+2, wb_valid T+3) and 1 cycle for illegal ops.
REQ-026 SHALL ignore req_valid outside IDLE (no latching, no queueing).

Reset
REQ-027 SHALL, while rstn=0, asynchronously force state IDLE, counter 0, ex_out_valid 0, wb_valid 0, stray_err 0, ex_sig 0, ex_src1 0, ex_src2 0, wb_rd 0, wb_data 0, wb_exc 0.
REQ-028 SHALL, on reset asserted mid-operation (ISSUE/WAIT/WB), abandon the op with no wb_valid pulse; a late ex_in_valid after release sets stray_err.
REQ-029 SHALL leave req_ready=1 in the first cycle after rstn deasserts.

Verification
REQ-030 SHALL cover: sig=0x00001 (mul), src1=6, src2=7, rd=5, exu returns 42 two cycles after issue -> single ex_out_valid pulse, wb_valid one cycle with rd=5, data=42, exc=0.
REQ-031 SHALL cover: sig=0x00003 (two bits) -> no ex_out_valid, wb_valid next cycle with exc=3'b010, data=0.
REQ-032 SHALL cover: legal op, exu never responds, TIMEOUT=100 -> wb_valid with exc=3'b111 exactly 100 cycles after entering WAIT.
REQ-033 SHALL cover: ex_in_valid on the timeout cycle with result 0xDEADBEEF -> wb_data=0xDEADBEEF, exc from exu, not 3'b111.
REQ-034 SHALL cover: req_valid held high during WAIT with different operands -> ignored, ex_sig/ex_src unchanged; ex_in_valid in IDLE -> stray_err=1 until reset.
REQ-035 SHALL cover: rstn pulled low in WAIT -> outputs at reset values immediately, no wb_valid, req_ready=1 after release.
